// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch/decode handshake bundle for the prefetch queue
interface fetch_queue_if #(parameter int IW = 9, parameter int AW = 16, parameter int DEPTH = 2);
  logic [AW-1:0] instr_addr;
  logic [IW-1:0] instr_in;
  logic fetch_valid;
  logic flush_ctrl;
  logic dec_ready;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] pc_out;
  logic instr_valid;
  logic fetch_stall;
  logic halted;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport slave(
    input instr_addr, instr_in, fetch_valid, flush_ctrl, dec_ready,
    output instr_out, pc_out, instr_valid, fetch_stall, halted, count
  );
  modport master(
    output instr_addr, instr_in, fetch_valid, flush_ctrl, dec_ready,
    input instr_out, pc_out, instr_valid, fetch_stall, halted, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: prefetch FIFO between instruction fetch and decode with flush and sticky halt
module fetch_queue #(
  parameter int IW = 9,
  parameter int AW = 16,
  parameter int DEPTH = 2,
  parameter logic [IW-1:0] HALT_WORD = 9'h1FF
) (
  input logic CLK,
  input logic reset_ctrl_n,
  fetch_queue_if.slave q
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [IW-1:0] word_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign q.instr_valid = cnt != '0 && state == RUN;
  assign q.fetch_stall = cnt == CW'(DEPTH) || state == HALTED;
  assign q.halted = state == HALTED;
  assign q.count = cnt;
  assign q.instr_out = word_mem[rd_ptr];
  assign q.pc_out = addr_mem[rd_ptr];
  assign push = q.fetch_valid && !q.fetch_stall && !q.flush_ctrl && state == RUN;
  assign pop = q.instr_valid && q.dec_ready;
  always_ff @(posedge CLK) begin
    if (!reset_ctrl_n) begin
      state <= RUN;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        word_mem[i] <= '0;
      end
    end else if (state == RUN) begin
      if (push) begin
        addr_mem[wr_ptr] <= q.instr_addr;
        word_mem[wr_ptr] <= q.instr_in;
        wr_ptr <= inc(wr_ptr);
      end
      if (pop && q.instr_out == HALT_WORD) begin
        state <= HALTED;
        cnt <= '0;
      end else if (q.flush_ctrl) begin
        cnt <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (pop) rd_ptr <= inc(rd_ptr);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and scoreboard checks of fetch_queue at DEPTH 2 and 3
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fetch_queue_if #(.IW(9), .AW(16), .DEPTH(2)) q ();
  fetch_queue_if #(.IW(9), .AW(16), .DEPTH(3)) q3 ();
  fetch_queue #(.IW(9), .AW(16), .DEPTH(2)) dut (.CLK(clk), .reset_ctrl_n(rst_n), .q(q));
  fetch_queue #(.IW(9), .AW(16), .DEPTH(3)) dut3 (.CLK(clk), .reset_ctrl_n(rst_n), .q(q3));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic fv, input logic [15:0] a, input logic [8:0] w, input logic dr, input logic fl);
    q.fetch_valid = fv;
    q.instr_addr = a;
    q.instr_in = w;
    q.dec_ready = dr;
    q.flush_ctrl = fl;
  endtask
  task automatic head(input string tag, input logic [8:0] w, input logic [15:0] a, input logic [1:0] c, input logic st);
    check({tag, ".valid"}, 32'(q.instr_valid), 32'(c != 0));
    check({tag, ".word"}, 32'(q.instr_out), 32'(w));
    check({tag, ".pc"}, 32'(q.pc_out), 32'(a));
    check({tag, ".count"}, 32'(q.count), 32'(c));
    check({tag, ".stall"}, 32'(q.fetch_stall), 32'(st));
  endtask
  task automatic idle(input string tag, input logic st, input logic h);
    check({tag, ".valid"}, 32'(q.instr_valid), 32'(0));
    check({tag, ".count"}, 32'(q.count), 32'(0));
    check({tag, ".stall"}, 32'(q.fetch_stall), 32'(st));
    check({tag, ".halted"}, 32'(q.halted), 32'(h));
  endtask
  initial begin
    logic [24:0] sb [$];
    logic [15:0] na;
    logic fv, dr, pu, po;
    drive(0, 0, 0, 0, 0);
    q3.fetch_valid = 0;
    q3.instr_addr = 0;
    q3.instr_in = 0;
    q3.dec_ready = 0;
    q3.flush_ctrl = 0;
    step();
    step();
    idle("reset", 0, 0);
    check("reset.word", 32'(q.instr_out), 0);
    check("reset.pc", 32'(q.pc_out), 0);
    rst_n = 1;
    drive(1, 16'h0000, 9'h011, 1, 0);
    step();
    head("t1a", 9'h011, 16'h0000, 1, 0);
    drive(1, 16'h0001, 9'h022, 1, 0);
    step();
    head("t1b", 9'h022, 16'h0001, 1, 0);
    drive(1, 16'h0002, 9'h033, 1, 0);
    step();
    head("t1c", 9'h033, 16'h0002, 1, 0);
    drive(0, 0, 0, 1, 0);
    step();
    idle("t1d", 0, 0);
    drive(1, 16'h0010, 9'h0AA, 0, 0);
    step();
    head("t2a", 9'h0AA, 16'h0010, 1, 0);
    drive(1, 16'h0011, 9'h0BB, 0, 0);
    step();
    head("t2b", 9'h0AA, 16'h0010, 2, 1);
    drive(1, 16'h0012, 9'h0CC, 0, 0);
    step();
    head("t2c", 9'h0AA, 16'h0010, 2, 1);
    drive(1, 16'h0012, 9'h0CC, 1, 0);
    step();
    head("t2d", 9'h0BB, 16'h0011, 1, 0);
    step();
    head("t2e", 9'h0CC, 16'h0012, 1, 0);
    drive(1, 16'h0013, 9'h0DD, 0, 0);
    step();
    head("t2f", 9'h0CC, 16'h0012, 2, 1);
    drive(1, 16'h0014, 9'h0EE, 1, 1);
    step();
    idle("t3a", 0, 0);
    drive(1, 16'h0020, 9'h055, 0, 0);
    step();
    head("t3b", 9'h055, 16'h0020, 1, 0);
    drive(0, 0, 0, 1, 0);
    step();
    idle("t3c", 0, 0);
    drive(1, 16'h0030, 9'h1FF, 0, 0);
    step();
    drive(1, 16'h0031, 9'h077, 0, 0);
    step();
    head("t4a", 9'h1FF, 16'h0030, 2, 1);
    drive(0, 0, 0, 1, 0);
    step();
    idle("t4b", 1, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'(16'h0040 + i), 9'h012, 1, 1'(i % 2));
      step();
    end
    idle("t4c", 1, 1);
    rst_n = 0;
    step();
    idle("t5a", 0, 0);
    check("t5a.word", 32'(q.instr_out), 0);
    check("t5a.pc", 32'(q.pc_out), 0);
    rst_n = 1;
    drive(1, 16'h0040, 9'h100, 0, 0);
    step();
    head("t5b", 9'h100, 16'h0040, 1, 0);
    drive(0, 0, 0, 1, 0);
    step();
    idle("t5c", 0, 0);
    drive(1, 16'h0050, 9'h1FF, 0, 0);
    step();
    drive(0, 0, 0, 1, 1);
    step();
    idle("t5d", 1, 1);
    drive(0, 0, 0, 0, 0);
    rst_n = 0;
    step();
    rst_n = 1;
    na = 16'h1000;
    for (int c = 0; c < 400; c++) begin
      check("sb.valid", 32'(q3.instr_valid), 32'(sb.size() != 0));
      check("sb.count", 32'(q3.count), 32'(sb.size()));
      check("sb.stall", 32'(q3.fetch_stall), 32'(sb.size() == 3));
      if (sb.size() != 0) check("sb.head", {7'd0, q3.pc_out, q3.instr_out}, 32'(sb[0]));
      fv = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      q3.fetch_valid = fv;
      q3.dec_ready = dr;
      q3.instr_addr = na;
      q3.instr_in = 9'($urandom_range(0, 255));
      pu = fv && sb.size() != 3;
      po = dr && sb.size() != 0;
      if (po) void'(sb.pop_front());
      if (pu) begin
        sb.push_back({q3.instr_addr, q3.instr_in});
        na++;
      end
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
